// File: rtl/cnt_pkg.sv
// Shared definitions for the up/down counter: saturate-mode names and Gray helper.
package cnt_pkg;

  localparam int CNT_WRAP = 0;
  localparam int CNT_SAT  = 1;

  // Binary to reflected Gray code.
  function automatic logic [31:0] to_gray(logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/dff_vec.sv
// W-bit D register, asynchronous active-high reset to zero. Holds the count state.
module dff_vec #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // State register; reset clears the register at once, without waiting for a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= '0;
    else     q <= d;
  end

endmodule

// File: rtl/counter_updown_mod.sv
// Modulo up/down counter with load, clear, wrap/saturate modes and Gray output.
// State lives in a dff_vec instance; next-state, clamp, tc and Gray logic are in this module.
module counter_updown_mod
  import cnt_pkg::*;
#(
  parameter int              WIDTH    = 4,
  parameter longint unsigned MODULO   = 16,
  parameter int              SATURATE = CNT_WRAP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_gray,
  output logic             tc,
  output logic             wrap
);

  // Reject parameter sets that cannot describe a valid range.
  if (WIDTH < 2 || WIDTH > 32)
    $error("counter_updown_mod: WIDTH must be within 2..32");
  if (MODULO < 2 || MODULO > (64'd1 << WIDTH))
    $error("counter_updown_mod: MODULO must be within 2..2**WIDTH");
  if (SATURATE != CNT_WRAP && SATURATE != CNT_SAT)
    $error("counter_updown_mod: SATURATE must be 0 or 1");

  localparam logic [WIDTH-1:0] Q_MAX = WIDTH'(MODULO - 64'd1);
  localparam bit               SAT   = (SATURATE == CNT_SAT);

  logic [WIDTH-1:0] q_nxt;
  logic             wrap_nxt;

  dff_vec #(.W(WIDTH)) u_state (
    .clk (clk),
    .rst (rst),
    .d   (q_nxt),
    .q   (q)
  );

  // Next-state selection with clr > load > en > hold priority; a wrap sets the pulse flag.
  always_comb begin
    q_nxt    = q;
    wrap_nxt = 1'b0;
    if (clr) begin
      q_nxt = '0;
    end else if (load) begin
      q_nxt = (load_val > Q_MAX) ? Q_MAX : load_val;
    end else if (en) begin
      if (up) begin
        if (q != Q_MAX)  q_nxt = q + 1'b1;
        else if (!SAT) begin
          q_nxt    = '0;
          wrap_nxt = 1'b1;
        end
      end else begin
        if (q != '0)     q_nxt = q - 1'b1;
        else if (!SAT) begin
          q_nxt    = Q_MAX;
          wrap_nxt = 1'b1;
        end
      end
    end
  end

  // Wrap pulse register: high for exactly the cycle after a wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) wrap <= 1'b0;
    else     wrap <= wrap_nxt;
  end

  // Terminal count: the next enabled edge would cross a range end.
  always_comb begin
    tc = en & ((up & (q == Q_MAX)) | (~up & (q == '0)));
  end

  // Gray view of the registered count.
  always_comb begin
    q_gray = WIDTH'(to_gray(32'(q)));
  end

endmodule

// File: tb/tb_counter_updown_mod.sv
// Self-checking bench: directed steps on WIDTH=4/MODULO=10 (wrap and saturate),
// then a random run on WIDTH=8/MODULO=256 against a behavioural model.
module tb_counter_updown_mod;
  import cnt_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  // shared stimulus for the two 4-bit instances
  logic       a_clr, a_load, a_en, a_up;
  logic [3:0] a_lv;
  // stimulus for the 8-bit instance
  logic       b_clr, b_load, b_en, b_up;
  logic [7:0] b_lv;

  logic [3:0] q0, g0, q1, g1;
  logic       tc0, w0, tc1, w1;
  logic [7:0] q2, g2;
  logic       tc2, w2;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string      tag;
    int         dut;
    logic [7:0] q;
    logic       wrap;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  counter_updown_mod #(.WIDTH(4), .MODULO(10), .SATURATE(CNT_WRAP)) d0 (
    .clk(clk), .rst(rst), .clr(a_clr), .load(a_load), .load_val(a_lv),
    .en(a_en), .up(a_up), .q(q0), .q_gray(g0), .tc(tc0), .wrap(w0));

  counter_updown_mod #(.WIDTH(4), .MODULO(10), .SATURATE(CNT_SAT)) d1 (
    .clk(clk), .rst(rst), .clr(a_clr), .load(a_load), .load_val(a_lv),
    .en(a_en), .up(a_up), .q(q1), .q_gray(g1), .tc(tc1), .wrap(w1));

  counter_updown_mod #(.WIDTH(8), .MODULO(256), .SATURATE(CNT_WRAP)) d2 (
    .clk(clk), .rst(rst), .clr(b_clr), .load(b_load), .load_val(b_lv),
    .en(b_en), .up(b_up), .q(q2), .q_gray(g2), .tc(tc2), .wrap(w2));

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(string tag, int dut, logic [7:0] q, logic wrap);
    exp_t e;
    e.tag = tag; e.dut = dut; e.q = q; e.wrap = wrap;
    sb.push_back(e);
  endtask

  // Advance one edge, then retire every pending expectation against its instance.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.dut)
        0: begin
          check({e.tag, " q"},    32'(q0), 32'(e.q));
          check({e.tag, " wrap"}, 32'(w0), 32'(e.wrap));
          check({e.tag, " gray"}, 32'(g0), to_gray(32'(q0)) & 32'hF);
        end
        1: begin
          check({e.tag, " q"},    32'(q1), 32'(e.q));
          check({e.tag, " wrap"}, 32'(w1), 32'(e.wrap));
        end
        default: begin
          check({e.tag, " q"},    32'(q2), 32'(e.q));
          check({e.tag, " wrap"}, 32'(w2), 32'(e.wrap));
          check({e.tag, " gray"}, 32'(g2), to_gray(32'(q2)) & 32'hFF);
        end
      endcase
    end
  endtask

  initial begin
    int         m, pq;
    logic       mw;
    logic [7:0] pg;
    rst = 1'b1;
    a_clr = 0; a_load = 0; a_en = 0; a_up = 1; a_lv = '0;
    b_clr = 0; b_load = 0; b_en = 0; b_up = 1; b_lv = '0;
    #12;
    check("reset q",    32'(q0), 0);
    check("reset gray", 32'(g0), 0);
    check("reset wrap", 32'(w0), 0);
    check("reset q8",   32'(q2), 0);
    @(negedge clk);
    rst = 1'b0;

    // 1: count up through the wrap
    a_en = 1; a_up = 1;
    pq = 0;
    for (int i = 1; i <= 12; i++) begin
      #1;
      check("t1 tc", 32'(tc0), 32'(pq == 9));
      push("t1", 0, 8'(i % 10), (i % 10) == 0);
      tick();
      pq = i % 10;
    end

    // 2: clear, then count down through the wrap
    a_clr = 1;
    push("t2 clr", 0, 8'd0, 1'b0);
    tick();
    a_clr = 0; a_up = 0;
    #1;
    check("t2 tc at 0", 32'(tc0), 1);
    push("t2 a", 0, 8'd9, 1'b1); tick();
    check("t2 gray9", 32'(g0), 32'b1101);
    push("t2 b", 0, 8'd8, 1'b0); tick();
    push("t2 c", 0, 8'd7, 1'b0); tick();

    // 3: saturating instance holds at both ends
    a_clr = 1;
    push("t3 clr", 1, 8'd0, 1'b0);
    tick();
    a_clr = 0; a_up = 1;
    for (int i = 1; i <= 12; i++) begin
      push("t3 up", 1, 8'((i > 9) ? 9 : i), 1'b0);
      tick();
    end
    a_up = 0;
    for (int i = 1; i <= 12; i++) begin
      push("t3 dn", 1, 8'((9 - i < 0) ? 0 : 9 - i), 1'b0);
      tick();
    end

    // 4: load clamp and priority
    a_en = 0; a_load = 1; a_lv = 4'hC;
    push("t4 clamp", 0, 8'd9, 1'b0); tick();
    a_clr = 1;
    push("t4 clr>load", 0, 8'd0, 1'b0); tick();
    a_clr = 0; a_en = 1; a_up = 1; a_lv = 4'd3;
    push("t4 load>en", 0, 8'd3, 1'b0); tick();
    a_lv = 4'd9;
    push("t4 load max", 0, 8'd9, 1'b0); tick();

    // 5: asynchronous reset mid-count
    a_en = 0; a_lv = 4'd6;
    push("t5 load6", 0, 8'd6, 1'b0); tick();
    a_load = 0;
    #2 rst = 1'b1;
    #1 check("t5 async q", 32'(q0), 0);
    #1 rst = 1'b0; a_en = 1; a_up = 1;
    push("t5 after rst", 0, 8'd1, 1'b0); tick();

    // 6: random run on the 8-bit instance against a model
    m = 0;
    pg = g2;
    for (int i = 0; i < 2000; i++) begin
      b_en   = ($urandom % 4) != 0;
      b_up   = $urandom % 2;
      b_load = ($urandom % 16) == 0;
      b_clr  = ($urandom % 64) == 0;
      b_lv   = 8'($urandom);
      mw = 0;
      if (b_clr) m = 0;
      else if (b_load) m = b_lv;
      else if (b_en && b_up) begin
        if (m == 255) begin m = 0; mw = 1; end else m++;
      end else if (b_en) begin
        if (m == 0) begin m = 255; mw = 1; end else m--;
      end
      push("t6", 2, 8'(m), mw);
      tick();
      if (b_en && !b_load && !b_clr)
        check("t6 gray step", 32'($countones(pg ^ g2) <= 1), 1);
      pg = g2;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
